// File: rtl/external_pulse_gen.sv
// external_pulse_gen: one registered off-chip pulse per accepted trigger, with delay, width and holdoff.
// Define EXT_PULSE_COUNT_EN to add the 32-bit pulse_count output.
module external_pulse_gen #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 trigger,
  input  logic [CNT_WIDTH-1:0] cfg_delay,
  input  logic [CNT_WIDTH-1:0] cfg_width,
  input  logic [CNT_WIDTH-1:0] cfg_holdoff,
  output logic                 external_output,
  output logic                 busy,
  output logic                 trigger_dropped
`ifdef EXT_PULSE_COUNT_EN
  ,
  output logic [31:0]          pulse_count
`endif
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DELAY   = 2'd1;
  localparam logic [1:0] HIGH    = 2'd2;
  localparam logic [1:0] HOLDOFF = 2'd3;

  localparam logic [CNT_WIDTH-1:0] ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic [CNT_WIDTH-1:0] width_q;
  logic [CNT_WIDTH-1:0] holdoff_q;
  logic                 latch_cfg;

  // The counter holds "cycles left minus one", so a width of 0 collapses to a single HIGH cycle.
  function automatic logic [CNT_WIDTH-1:0] width_reload(input logic [CNT_WIDTH-1:0] w);
    return (w == ZERO) ? ZERO : w - ONE;
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    latch_cfg = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          latch_cfg = 1'b1;
          if (cfg_delay == ZERO) begin
            state_nxt = HIGH;
            cnt_nxt   = width_reload(cfg_width);
          end else begin
            state_nxt = DELAY;
            cnt_nxt   = cfg_delay - ONE;
          end
        end
      end
      DELAY: begin
        if (cnt == ZERO) begin
          state_nxt = HIGH;
          cnt_nxt   = width_reload(width_q);
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      HIGH: begin
        if (cnt == ZERO) begin
          if (holdoff_q == ZERO) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = HOLDOFF;
            cnt_nxt   = holdoff_q - ONE;
          end
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      HOLDOFF: begin
        if (cnt == ZERO) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state           <= IDLE;
      cnt             <= ZERO;
      width_q         <= ZERO;
      holdoff_q       <= ZERO;
      external_output <= 1'b0;
      busy            <= 1'b0;
      trigger_dropped <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      // Outputs are decoded from the next state so they line up with the state register.
      external_output <= (state_nxt == HIGH);
      busy            <= (state_nxt != IDLE);
      trigger_dropped <= trigger && (state != IDLE);
      if (latch_cfg) begin
        width_q   <= cfg_width;
        holdoff_q <= cfg_holdoff;
      end
    end
  end

`ifdef EXT_PULSE_COUNT_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pulse_count <= 32'd0;
    end else if ((state_nxt == HIGH) && (state != HIGH)) begin
      pulse_count <= pulse_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_external_pulse_gen.sv
// Scoreboard bench for external_pulse_gen: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_external_pulse_gen;

  localparam int CW = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b1;
  logic          trigger = 1'b0;
  logic [CW-1:0] cfg_delay = '0;
  logic [CW-1:0] cfg_width = '0;
  logic [CW-1:0] cfg_holdoff = '0;
  logic          external_output;
  logic          busy;
  logic          trigger_dropped;
`ifdef EXT_PULSE_COUNT_EN
  logic [31:0]   pulse_count;
`endif

  external_pulse_gen #(.CNT_WIDTH(CW)) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .trigger         (trigger),
    .cfg_delay       (cfg_delay),
    .cfg_width       (cfg_width),
    .cfg_holdoff     (cfg_holdoff),
    .external_output (external_output),
    .busy            (busy),
    .trigger_dropped (trigger_dropped)
`ifdef EXT_PULSE_COUNT_EN
    ,
    .pulse_count     (pulse_count)
`endif
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    int         id;
    int         cyc;
    int         off;
    logic [2:0] v;   // {external_output, busy, trigger_dropped}
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  // Hand-computed windows, offsets relative to the trigger cycle t: output high for
  // [t+oo, t+oo+ol), busy for [t+1, t+bl], drop strobe at t+dr+1 when dr>0.
  task automatic push_window(input int id, input int t, input int oo, input int ol,
                             input int bl, input int dr, input int upto);
    exp_t x;
    for (int c = 0; c <= upto; c++) begin
      x.id   = id;
      x.cyc  = t + c;
      x.off  = c;
      x.v[2] = (c >= oo) && (c < oo + ol);
      x.v[1] = (c >= 1) && (c <= bl);
      x.v[0] = (dr > 0) && (c == dr + 1);
      q.push_back(x);
    end
  endtask

  task automatic run_vec(input int id, input int d, input int w, input int h,
                         input int oo, input int ol, input int bl,
                         input int dr, input int chg_off, input int chg_w);
    int t;
    @(posedge aclk); #1;
    t           = cyc;
    cfg_delay   = CW'(d);
    cfg_width   = CW'(w);
    cfg_holdoff = CW'(h);
    trigger     = 1'b1;
    push_window(id, t, oo, ol, bl, dr, bl);
    for (int k = 1; k <= bl; k++) begin
      @(posedge aclk); #1;
      trigger = (k == dr);
      if (k == chg_off) cfg_width = CW'(chg_w);
    end
    trigger = 1'b0;
  endtask

  always @(negedge aclk) begin
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      check($sformatf("vec%0d@+%0d out/busy/drop", e.id, e.off),
            {29'd0, external_output, busy, trigger_dropped}, {29'd0, e.v});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    #2 aresetn = 1'b0;
    #1;
    check("reset_out",     {31'd0, external_output}, 32'd0);
    check("reset_busy",    {31'd0, busy},            32'd0);
    check("reset_dropped", {31'd0, trigger_dropped}, 32'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;

    run_vec(1, 0, 1, 0, 1, 1, 1, 0, 0, 0);     // minimal pulse
    run_vec(2, 3, 5, 4, 4, 5, 12, 0, 0, 0);    // delay/width/holdoff
    run_vec(3, 0, 1, 0, 1, 1, 1, 0, 0, 0);     // accepted on IDLE re-entry at T+13
    run_vec(4, 3, 5, 4, 4, 5, 12, 6, 0, 0);    // trigger during HIGH dropped
    run_vec(5, 2, 0, 1, 3, 1, 4, 0, 2, 9);     // width 0, cfg_width changed in flight
    run_vec(6, 15, 15, 15, 16, 15, 45, 0, 0, 0); // all-ones full range
    run_vec(7, 1, 2, 2, 2, 2, 5, 1, 0, 0);     // trigger during DELAY dropped

    // Reset in the middle of HIGH must clear outputs without an edge.
    @(posedge aclk); #1;
    t           = cyc;
    cfg_delay   = CW'(1);
    cfg_width   = CW'(6);
    cfg_holdoff = CW'(0);
    trigger     = 1'b1;
    push_window(8, t, 2, 6, 7, 0, 4);
    for (int k = 1; k <= 5; k++) begin
      @(posedge aclk); #1;
      trigger = 1'b0;
    end
    aresetn = 1'b0;
    #1;
    check("abort_out",     {31'd0, external_output}, 32'd0);
    check("abort_busy",    {31'd0, busy},            32'd0);
    check("abort_dropped", {31'd0, trigger_dropped}, 32'd0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;

    run_vec(9, 0, 2, 1, 1, 2, 3, 0, 0, 0);     // first edge after release honours trigger
    run_vec(10, 1, 2, 2, 2, 2, 5, 1, 0, 0);
    run_vec(11, 0, 1, 0, 1, 1, 1, 0, 0, 0);

    for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge aclk);
    check("queue_drained", q.size(), 32'd0);
`ifdef EXT_PULSE_COUNT_EN
    @(negedge aclk);
    check("pulse_count", pulse_count, 32'd3);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/external_pulse_gen.md
EXTERNAL_PULSE_GEN -- requirements
Module: external_pulse_gen

Interface
REQ-001 Parameter CNT_WIDTH, default 16, sets the width of the delay, width and holdoff counters and config ports.
REQ-002 aclk  input  1  sole clock; all logic on rising edge.
REQ-003 aresetn  input  1  asynchronous, active-low reset.
REQ-004 trigger  input  1  single-cycle request to emit one external pulse; already synchronous to aclk.
REQ-005 cfg_delay  input  CNT_WIDTH  cycles from accepted trigger to output rising edge.
REQ-006 cfg_width  input  CNT_WIDTH  output high time in cycles; 0 treated as 1.
REQ-007 cfg_holdoff  input  CNT_WIDTH  dead time in cycles after output falling edge before a new trigger is accepted.
REQ-008 external_output  output  1  registered pulse driven to the off-chip pin.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 trigger_dropped  output  1  one-cycle strobe when a trigger arrives while busy.

Function
REQ-011 The FSM SHALL have four states: IDLE, DELAY, HIGH, HOLDOFF.
REQ-012 In IDLE, trigger=1 at edge T SHALL latch cfg_delay, cfg_width and cfg_holdoff into internal registers; later cfg changes do not affect the pulse in flight.
REQ-013 From IDLE with trigger: latched delay=0 -> HIGH at T+1; otherwise -> DELAY, then HIGH after exactly delay cycles (external_output first high at edge T+1+delay).
REQ-014 external_output SHALL be 1 exactly in HIGH, for max(cfg_width,1) consecutive cycles; it is a flop output with no combinational path from trigger.
REQ-015 After HIGH: latched holdoff=0 -> IDLE; otherwise -> HOLDOFF for exactly holdoff cycles, then IDLE.
REQ-016 A trigger is accepted in IDLE only; the earliest re-accept is the cycle IDLE is re-entered.
REQ-017 trigger=1 in any non-IDLE state SHALL be ignored and SHALL assert trigger_dropped on the following cycle for one cycle per dropped trigger cycle.
REQ-018 Counters SHALL count down from the latched value and SHALL NOT wrap; all-ones (2^CNT_WIDTH-1) is a legal full-range value.
REQ-019 busy SHALL be 0 in IDLE and 1 in DELAY, HIGH and HOLDOFF, registered with the state.

Reset
REQ-020 aresetn=0 SHALL immediately force state=IDLE, external_output=0, busy=0, trigger_dropped=0, all counters and latched configuration=0, without waiting for aclk.
REQ-021 Reset asserted mid-pulse SHALL drop external_output at once; the aborted pulse is not resumed.
REQ-022 The first trigger SHALL be honoured on the first rising edge at which aresetn is sampled high.

Configuration
REQ-023 Macro EXT_PULSE_COUNT_EN defined: adds output pulse_count[31:0], reset 0, incremented on every HIGH entry, wrapping 0xFFFFFFFF->0.
REQ-024 Macro EXT_PULSE_COUNT_EN undefined: pulse_count port and its logic are absent; all other behaviour is identical.

Verification
REQ-025 delay=0, width=1, holdoff=0, trigger at T -> external_output high only at cycle T+1; busy high only at T+1.
REQ-026 delay=3, width=5, holdoff=4, trigger at T -> output high T+4..T+8, busy T+1..T+12, new trigger at T+13 accepted.
REQ-027 Same config, second trigger at T+6 -> trigger_dropped high at T+7 only; the first pulse is unchanged.
REQ-028 width=0 -> exactly one high cycle; cfg_width changed to 9 at T+2 -> in-flight pulse length unchanged.
REQ-029 aresetn dropped at T+5 during HIGH -> external_output=0 and busy=0 before the next aclk edge; trigger after release starts a clean pulse.
REQ-030 With EXT_PULSE_COUNT_EN, 3 accepted plus 1 dropped trigger -> pulse_count=3; without the macro, the build has no pulse_count port.
